// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite channel bundle used on both sides of the arbiter.
// The master modport drives requests; the slave modport answers them.
interface axi4_lite_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Round-robin N-to-1 AXI4-Lite arbiter, one outstanding transaction.
// Grant and direction are latched in IDLE and held until the response.
module axi4_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter bit WRITE_FIRST = 1'b0
) (
  input logic               clk,
  input logic               rst,
  axi4_lite_interface.slave m [NUM_MASTERS],
  axi4_lite_interface.master s
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_W,
    S_B
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] w_grant_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic          r_aw_done;
  logic          w_aw_done_nxt;
  logic          r_w_done;
  logic          w_w_done_nxt;

  logic [NUM_MASTERS-1:0] w_m_arvalid;
  logic [NUM_MASTERS-1:0] w_m_awvalid;
  logic [NUM_MASTERS-1:0] w_m_wvalid;
  logic [NUM_MASTERS-1:0] w_m_rready;
  logic [NUM_MASTERS-1:0] w_m_bready;
  logic [ADDR_WIDTH-1:0]  w_m_araddr [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  w_m_awaddr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  w_m_wdata  [NUM_MASTERS];
  logic [SW-1:0]          w_m_wstrb  [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] w_m_arready;
  logic [NUM_MASTERS-1:0] w_m_awready;
  logic [NUM_MASTERS-1:0] w_m_wready;
  logic [NUM_MASTERS-1:0] w_m_rvalid;
  logic [NUM_MASTERS-1:0] w_m_bvalid;
  logic [NUM_MASTERS-1:0] w_m_rsel;
  logic [NUM_MASTERS-1:0] w_m_bsel;
  logic [NUM_MASTERS-1:0] w_req;

  logic                  w_s_arvalid;
  logic [ADDR_WIDTH-1:0] w_s_araddr;
  logic                  w_s_awvalid;
  logic [ADDR_WIDTH-1:0] w_s_awaddr;
  logic                  w_s_wvalid;
  logic [DATA_WIDTH-1:0] w_s_wdata;
  logic [SW-1:0]         w_s_wstrb;
  logic                  w_s_rready;
  logic                  w_s_bready;

  logic [IW-1:0] w_win;
  logic          w_win_wr;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_b_hs;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_m
    assign w_m_arvalid[gi] = m[gi].arvalid;
    assign w_m_awvalid[gi] = m[gi].awvalid;
    assign w_m_wvalid[gi]  = m[gi].wvalid;
    assign w_m_rready[gi]  = m[gi].rready;
    assign w_m_bready[gi]  = m[gi].bready;
    assign w_m_araddr[gi]  = m[gi].araddr;
    assign w_m_awaddr[gi]  = m[gi].awaddr;
    assign w_m_wdata[gi]   = m[gi].wdata;
    assign w_m_wstrb[gi]   = m[gi].wstrb;

    assign m[gi].arready = w_m_arready[gi];
    assign m[gi].awready = w_m_awready[gi];
    assign m[gi].wready  = w_m_wready[gi];
    assign m[gi].rvalid  = w_m_rvalid[gi];
    assign m[gi].bvalid  = w_m_bvalid[gi];
    assign m[gi].rdata   = w_m_rsel[gi] ? s.rdata : '0;
    assign m[gi].rresp   = w_m_rsel[gi] ? s.rresp : 2'b00;
    assign m[gi].bresp   = w_m_bsel[gi] ? s.bresp : 2'b00;
  end

  assign w_req = w_m_arvalid | w_m_awvalid;

  assign s.arvalid = w_s_arvalid;
  assign s.araddr  = w_s_araddr;
  assign s.awvalid = w_s_awvalid;
  assign s.awaddr  = w_s_awaddr;
  assign s.wvalid  = w_s_wvalid;
  assign s.wdata   = w_s_wdata;
  assign s.wstrb   = w_s_wstrb;
  assign s.rready  = w_s_rready;
  assign s.bready  = w_s_bready;

  assign w_ar_hs = w_s_arvalid & s.arready;
  assign w_r_hs  = s.rvalid & w_s_rready;
  assign w_aw_hs = w_s_awvalid & s.awready;
  assign w_w_hs  = w_s_wvalid & s.wready;
  assign w_b_hs  = s.bvalid & w_s_bready;

  // search starts one past the last completed master
  always_comb begin
    int   v_idx;
    logic v_found;
    v_idx   = 0;
    v_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_MASTERS) begin
        v_idx = v_idx - NUM_MASTERS;
      end
      if (!v_found && w_req[v_idx]) begin
        v_found = 1'b1;
        w_win   = IW'(v_idx);
      end
    end
  end

  assign w_win_wr = WRITE_FIRST ? w_m_awvalid[w_win]
                                : !w_m_arvalid[w_win];

  always_comb begin
    w_s_arvalid = 1'b0;
    w_s_araddr  = '0;
    w_s_awvalid = 1'b0;
    w_s_awaddr  = '0;
    w_s_wvalid  = 1'b0;
    w_s_wdata   = '0;
    w_s_wstrb   = '0;
    w_s_rready  = 1'b0;
    w_s_bready  = 1'b0;
    w_m_arready = '0;
    w_m_awready = '0;
    w_m_wready  = '0;
    w_m_rvalid  = '0;
    w_m_bvalid  = '0;
    w_m_rsel    = '0;
    w_m_bsel    = '0;
    unique case (r_state)
      S_AR: begin
        w_s_arvalid          = w_m_arvalid[r_grant];
        w_s_araddr           = w_m_araddr[r_grant];
        w_m_arready[r_grant] = s.arready;
      end
      S_R: begin
        w_s_rready          = w_m_rready[r_grant];
        w_m_rvalid[r_grant] = s.rvalid;
        w_m_rsel[r_grant]   = 1'b1;
      end
      S_W: begin
        w_s_awvalid          = w_m_awvalid[r_grant] & ~r_aw_done;
        w_s_awaddr           = w_m_awaddr[r_grant];
        w_s_wvalid           = w_m_wvalid[r_grant] & ~r_w_done;
        w_s_wdata            = w_m_wdata[r_grant];
        w_s_wstrb            = w_m_wstrb[r_grant];
        w_m_awready[r_grant] = s.awready & ~r_aw_done;
        w_m_wready[r_grant]  = s.wready & ~r_w_done;
      end
      S_B: begin
        w_s_bready          = w_m_bready[r_grant];
        w_m_bvalid[r_grant] = s.bvalid;
        w_m_bsel[r_grant]   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    unique case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_grant_nxt = w_win;
          w_state_nxt = w_win_wr ? S_W : S_AR;
        end
      end
      S_AR: begin
        if (w_ar_hs) begin
          w_state_nxt = S_R;
        end
      end
      S_R: begin
        if (w_r_hs) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_grant;
        end
      end
      S_W: begin
        // AW and W may finish in either order or together
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_state_nxt   = S_B;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_aw_done_nxt = r_aw_done | w_aw_hs;
          w_w_done_nxt  = r_w_done | w_w_hs;
        end
      end
      S_B: begin
        if (w_b_hs) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_grant;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_ptr     <= LAST;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end
endmodule
